// File: rtl/indirim_hesaplayici_seq.sv
// Price-discount engine: one rate step per clock on a price held in kurus (hundredths).
// Rate tables can be written only while idle. A rejected write raises cfg_drop for one cycle.
module indirim_hesaplayici_seq #(
    parameter int          PRICE_W     = 13,
    parameter int          N_TIP       = 5,
    parameter int          TIP_W       = $clog2(N_TIP),
    parameter int          MARKUP_PCT  = 10,
    parameter int          CAP         = 5000,
    parameter int          FLOOR_PCT   = 75,
    parameter logic [15:0] EXEMPT_MASK = 16'h0005,
    parameter logic [15:0] FLOOR_MASK  = 16'h0120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PRICE_W-1:0] urun_fiyati,
    input  logic [1:0]         pazarlik,
    input  logic [TIP_W-1:0]   musteri_tipi,
    input  logic [1:0]         musteri_davranisi,
    input  logic [3:0]         urun_tipi,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PRICE_W-1:0] out_tam,
    output logic [6:0]         out_kurus,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [TIP_W-1:0]   cfg_addr,
    input  logic [6:0]         cfg_data,
    output logic               cfg_drop
);
    localparam int PW = PRICE_W + 8;
    localparam int XW = PW + 8;
    localparam logic [PW-1:0] CAP_P = PW'(CAP * 100);
    localparam logic [6:0] PAZ_DEF [4] = '{7'd0, 7'd3, 7'd8, 7'd19};
    localparam logic [6:0] TIP_DEF [5] = '{7'd2, 7'd10, 7'd15, 7'd0, 7'd1};

    typedef enum logic [2:0] {IDLE, STG1, STG2, STG3, STG4, FIN, DONE} state_t;

    state_t             state_q;
    logic [PW-1:0]      p_q, p0_q;
    logic [1:0]         pz_q, dav_q;
    logic [TIP_W-1:0]   mt_q;
    logic [3:0]         urun_q;
    logic               out_valid_q, cfg_drop_q;
    logic [PRICE_W-1:0] out_tam_q;
    logic [6:0]         out_kurus_q;

    logic [6:0] paz_tbl_q [4];
    logic [6:0] tip_tbl_q [N_TIP];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_tam   = out_tam_q;
    assign out_kurus = out_kurus_q;
    assign cfg_drop  = cfg_drop_q;

    // Rate tables: oversized writes clamp to 100 %.
    logic [6:0] cfg_val;
    logic       cfg_ok;
    assign cfg_val = (cfg_data > 7'd100) ? 7'd100 : cfg_data;
    assign cfg_ok  = (state_q == IDLE) &&
                     (cfg_sel ? (32'(cfg_addr) < 32'(N_TIP)) : (32'(cfg_addr) < 32'd4));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_paz
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    paz_tbl_q[gi] <= PAZ_DEF[gi];
                else if (cfg_we && cfg_ok && !cfg_sel && 32'(cfg_addr) == gi)
                    paz_tbl_q[gi] <= cfg_val;
            end
        end
        for (gi = 0; gi < N_TIP; gi++) begin : g_tip
            logic [6:0] def_val;
            if (gi < 5) begin : g_def
                assign def_val = TIP_DEF[gi];
            end else begin : g_zero
                assign def_val = 7'd0;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    tip_tbl_q[gi] <= def_val;
                else if (cfg_we && cfg_ok && cfg_sel && 32'(cfg_addr) == gi)
                    tip_tbl_q[gi] <= cfg_val;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_drop_q <= 1'b0;
        else        cfg_drop_q <= cfg_we && !cfg_ok;
    end

    logic [6:0]    tip_mt, tip_one, paz_r;
    logic [7:0]    rate;
    logic          markup, rude, exempt, floor_t;
    logic [XW-1:0] step_prod, floor_prod;
    logic [PW-1:0] delta, p_step, floor_p, p_fin;

    always_comb begin
        tip_mt  = '0;
        tip_one = '0;
        for (int k = 0; k < N_TIP; k++) begin
            if (32'(mt_q) == k) tip_mt = tip_tbl_q[k];
            if (k == 1)         tip_one = tip_tbl_q[k];
        end
        paz_r   = paz_tbl_q[pz_q];
        rude    = (dav_q == 2'd0);
        exempt  = EXEMPT_MASK[urun_q];
        floor_t = FLOOR_MASK[urun_q];

        rate   = '0;
        markup = 1'b0;
        case (state_q)
            STG1: begin
                if (!rude)       rate = {1'b0, paz_r};
                else if (!exempt) rate = {1'b0, (tip_mt > paz_r) ? tip_mt : paz_r};
            end
            STG2: begin
                if (rude) begin
                    rate   = 8'(MARKUP_PCT);
                    markup = 1'b1;
                end else begin
                    rate = {1'b0, tip_mt};
                end
            end
            STG3: if (!rude && 32'(mt_q) == 2) rate = {1'b0, tip_one};
            STG4: if (!rude && dav_q == 2'd2)  rate = 8'd5;
            default: ;
        endcase

        step_prod  = XW'(p_q) * XW'(rate);
        delta      = PW'(step_prod / XW'(100));
        p_step     = markup ? (p_q + delta) : (p_q - delta);

        floor_prod = XW'(p0_q) * XW'(FLOOR_PCT);
        floor_p    = PW'(floor_prod / XW'(100));

        if (rude)         p_fin = (p_q > CAP_P) ? CAP_P : p_q;
        else if (exempt)  p_fin = p0_q;
        else if (floor_t) p_fin = (p_q < floor_p) ? floor_p : p_q;
        else              p_fin = p_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            p0_q        <= '0;
            pz_q        <= '0;
            dav_q       <= '0;
            mt_q        <= '0;
            urun_q      <= '0;
            out_valid_q <= 1'b0;
            out_tam_q   <= '0;
            out_kurus_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        p_q     <= PW'(urun_fiyati) * PW'(100);
                        p0_q    <= PW'(urun_fiyati) * PW'(100);
                        pz_q    <= pazarlik;
                        mt_q    <= musteri_tipi;
                        dav_q   <= musteri_davranisi;
                        urun_q  <= urun_tipi;
                        state_q <= STG1;
                    end
                end
                STG1: begin p_q <= p_step; state_q <= STG2; end
                STG2: begin p_q <= p_step; state_q <= STG3; end
                STG3: begin p_q <= p_step; state_q <= STG4; end
                STG4: begin p_q <= p_step; state_q <= FIN;  end
                FIN: begin
                    p_q         <= p_fin;
                    out_tam_q   <= PRICE_W'(p_fin / PW'(100));
                    out_kurus_q <= 7'(p_fin % PW'(100));
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_indirim_hesaplayici_seq.sv
// Directed bench for indirim_hesaplayici_seq: hand-computed prices, config port, backpressure and reset.
module tb_indirim_hesaplayici_seq;
    localparam int PRICE_W = 13;
    localparam int TIP_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PRICE_W-1:0] urun_fiyati = '0;
    logic [1:0]         pazarlik = '0;
    logic [TIP_W-1:0]   musteri_tipi = '0;
    logic [1:0]         musteri_davranisi = '0;
    logic [3:0]         urun_tipi = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PRICE_W-1:0] out_tam;
    logic [6:0]         out_kurus;
    logic               cfg_we = 1'b0;
    logic               cfg_sel = 1'b0;
    logic [TIP_W-1:0]   cfg_addr = '0;
    logic [6:0]         cfg_data = '0;
    logic               cfg_drop;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    int acc_edge = 0;

    indirim_hesaplayici_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .urun_fiyati(urun_fiyati), .pazarlik(pazarlik), .musteri_tipi(musteri_tipi),
        .musteri_davranisi(musteri_davranisi), .urun_tipi(urun_tipi),
        .out_valid(out_valid), .out_ready(out_ready), .out_tam(out_tam), .out_kurus(out_kurus),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_drop(cfg_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int price, input int pz, input int mt, input int dav, input int ur);
        urun_fiyati       = PRICE_W'(price);
        pazarlik          = 2'(pz);
        musteri_tipi      = TIP_W'(mt);
        musteri_davranisi = 2'(dav);
        urun_tipi         = 4'(ur);
        in_valid          = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        acc_edge = edge_cnt;
    endtask

    task automatic finish_req(input string tag, input int exp_tam, input int exp_kur, input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        $display("%s: latency=%0d tam=%0d kurus=%0d", tag, edge_cnt - acc_edge, out_tam, out_kurus);
        check({tag, "_latency"}, 32'(edge_cnt - acc_edge), 32'd5);
        check({tag, "_tam"}, 32'(out_tam), 32'(exp_tam));
        check({tag, "_kurus"}, 32'(out_kurus), 32'(exp_kur));
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_tam"}, 32'(out_tam), 32'(exp_tam));
            check({tag, "_hold_kurus"}, 32'(out_kurus), 32'(exp_kur));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input int price, input int pz, input int mt, input int dav,
                       input int ur, input int exp_tam, input int exp_kur);
        start_req(price, pz, mt, dav, ur);
        finish_req(tag, exp_tam, exp_kur, 0);
    endtask

    task automatic cfg_write(input string tag, input int sel, input int addr, input int data, input int exp_drop);
        cfg_we   = 1'b1;
        cfg_sel  = 1'(sel);
        cfg_addr = TIP_W'(addr);
        cfg_data = 7'(data);
        tick();
        cfg_we = 1'b0;
        $display("%s: cfg_drop=%0d", tag, cfg_drop);
        check({tag, "_drop"}, 32'(cfg_drop), 32'(exp_drop));
        tick();
        check({tag, "_drop_clear"}, 32'(cfg_drop), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_tam", 32'(out_tam), 32'd0);
        check("rst_out_kurus", 32'(out_kurus), 32'd0);
        check("rst_cfg_drop", 32'(cfg_drop), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run("neutral_1000", 1000, 1, 1, 1, 3, 873, 0);
        run("neutral_999", 999, 1, 3, 1, 3, 969, 3);
        run("rude_4800", 4800, 3, 2, 0, 1, 4276, 80);
        run("rude_cap", 8000, 0, 0, 0, 0, 5000, 0);
        run("rude_tipmax", 1000, 1, 2, 0, 3, 935, 0);
        run("all_disc", 1000, 3, 2, 2, 3, 588, 67);
        run("all_disc_floor", 1000, 3, 2, 2, 5, 750, 0);
        run("exempt_1234", 1234, 3, 2, 1, 2, 1234, 0);

        // Config: write in IDLE, then use it
        cfg_write("cfg_tip3_50", 1, 3, 50, 0);
        run("cfg_tip3_use", 200, 0, 3, 1, 1, 100, 0);
        cfg_write("cfg_paz_oob", 0, 4, 7, 1);
        cfg_write("cfg_tip_oob", 1, 5, 7, 1);

        // Write while busy (STG2) is dropped
        start_req(1000, 1, 1, 1, 3);
        tick();
        cfg_we   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_addr = 3'd3;
        cfg_data = 7'd0;
        tick();
        cfg_we = 1'b0;
        $display("busy_write: cfg_drop=%0d", cfg_drop);
        check("busy_write_drop", 32'(cfg_drop), 32'd1);
        tick();
        check("busy_write_drop_clear", 32'(cfg_drop), 32'd0);
        finish_req("busy_req", 873, 0, 0);
        run("busy_table_kept", 200, 0, 3, 1, 1, 100, 0);

        // Same-edge write (clamped 120 -> 100 %) and accept
        cfg_we   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_addr = 3'd4;
        cfg_data = 7'd120;
        run("clamp_same_edge", 500, 0, 4, 1, 1, 0, 0);

        // Backpressure: hold DONE for three cycles
        start_req(1000, 1, 1, 1, 3);
        finish_req("backpressure", 873, 0, 3);

        // Reset during STG2
        start_req(200, 0, 3, 1, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid_reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_in_ready", 32'(in_ready), 32'd1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_no_valid", 32'(out_valid), 32'd0);
        run("post_reset_tip3", 200, 0, 3, 1, 1, 200, 0);
        run("post_reset_tip4", 500, 0, 4, 1, 1, 495, 0);
        run("post_reset_neutral", 1000, 1, 1, 1, 3, 873, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
